// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// ALU operation and ALU B-source selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_SD    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction classifier; anything not recognised is flagged illegal.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int BNE_EN = 1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic       o_is_ld,
  output logic       o_is_sd,
  output logic       o_is_br,
  output logic       o_is_op,
  output logic       o_is_opimm,
  output logic       o_illegal
);

  logic w_br_f3_ok;

  // Only BEQ, plus BNE when enabled, are valid branch flavours.
  assign w_br_f3_ok = (i_funct3 == F3_BEQ) || ((BNE_EN != 0) && (i_funct3 == F3_BNE));

  assign o_is_ld    = (i_opcode == OPC_LD);
  assign o_is_sd    = (i_opcode == OPC_SD);
  assign o_is_br    = (i_opcode == OPC_BR) && w_br_f3_ok;
  assign o_is_op    = (i_opcode == OPC_OP);
  assign o_is_opimm = (i_opcode == OPC_OPIMM);
  assign o_illegal  = !(o_is_ld || o_is_sd || o_is_br || o_is_op || o_is_opimm);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RISC-V control sequencer with memory handshake stalls, illegal-opcode
// trap and retired-instruction counter.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1,
  parameter int BNE_EN        = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             pc_source,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instret;
  logic             w_rdy;
  logic             w_retire;
  logic             w_is_ld, w_is_sd, w_is_br, w_is_op, w_is_opimm, w_illegal;

  assign w_rdy = mem_ready || (MEM_HANDSHAKE == 0);

  riscv_ctrl_decode #(
    .BNE_EN(BNE_EN)
  ) u_decode (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .o_is_ld   (w_is_ld),
    .o_is_sd   (w_is_sd),
    .o_is_br   (w_is_br),
    .o_is_op   (w_is_op),
    .o_is_opimm(w_is_opimm),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:  if (w_rdy) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = w_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (w_is_ld || w_is_sd)        w_next_state = ST_MEM;
        else if (w_is_br)              w_next_state = ST_FETCH;
        else if (w_is_op || w_is_opimm) w_next_state = ST_WB;
        else                           w_next_state = ST_TRAP;
      end
      ST_MEM:    if (w_rdy) w_next_state = w_is_sd ? ST_FETCH : ST_WB;
      ST_WB:     w_next_state = ST_FETCH;
      ST_TRAP:   w_next_state = ST_TRAP;
      default:   w_next_state = ST_TRAP;
    endcase
  end

  // An instruction retires on the transition that returns it to FETCH.
  assign w_retire = ((r_state == ST_EXEC) && w_is_br) ||
                    ((r_state == ST_MEM) && w_rdy && w_is_sd) ||
                    (r_state == ST_WB);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign instret = r_instret;

  always_comb begin
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    mem_to_reg    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 1'b0;
    halted        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = w_rdy;
        pc_write  = w_rdy;
      end
      ST_DECODE: alu_src_b = SRCB_SHIMM;
      ST_EXEC: begin
        alu_src_a = 1'b1;
        if (w_is_ld || w_is_sd) begin
          alu_src_b = SRCB_IMM;
        end else if (w_is_br) begin
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
          branch_ne     = (funct3 == F3_BNE);
        end else if (w_is_op) begin
          alu_op = ALU_FUNCT;
        end else if (w_is_opimm) begin
          alu_op    = ALU_FUNCT;
          alu_src_b = SRCB_IMM;
        end
      end
      ST_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = w_is_ld;
        mem_write = w_is_sd;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_ld;
      end
      ST_TRAP: halted = 1'b1;
      default: ;
    endcase
    // Reset forces every control line low without waiting for a clock edge.
    if (!reset_n) begin
      alu_op        = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      mem_to_reg    = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule
